// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the responder FSM state type, the data word width and the
// byte-enable to bit-mask expansion used by the byte-writable store.
package mips_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

  // Expand 4 byte enables into a 32-bit write mask (be[i] -> bits [8i+7:8i]).
  function automatic logic [WORD_W-1:0] be_to_mask(input logic [3:0] be);
    logic [WORD_W-1:0] mask;
    mask = {WORD_W{1'b0}};
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dm_wait_ram.sv
// Word-addressed store with byte-enable write.
// Ports:
//   clk     - clock; writes happen on its rising edge
//   we_i    - write strobe for this edge
//   waddr_i - write word index
//   wdata_i - write data
//   be_i    - byte enables of the write
//   raddr_i - read word index (asynchronous read)
//   rdata_o - word at raddr_i
// Contents are deliberately not reset.
module dm_wait_ram
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [3:0]        be_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [0:DEPTH-1];
  logic [WORD_W-1:0] mask_s;

  assign mask_s  = be_to_mask(be_i);
  assign rdata_o = mem_q[raddr_i];

  // Merge the enabled bytes into the addressed word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= (mem_q[waddr_i] & ~mask_s) | (wdata_i & mask_s);
    end
  end

endmodule

// File: rtl/dm_wait_resp.sv
// Data-memory responder with request/acknowledge handshake and a fixed
// number of wait states between acceptance and acknowledge.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   req        - request strobe, accepted only while busy=0
//   we         - 1 = store, 0 = load (sampled with req)
//   addr       - word address; values >= DEPTH are out of range
//   wdata, be  - store data and byte enables
//   busy       - high from the cycle after acceptance through the ack cycle
//   ack        - one-cycle completion pulse
//   rdata      - load result, zero unless ack carries an in-range load
//   err        - high with ack for an out-of-range address
module dm_wait_resp
  import mips_mem_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [3:0]        be,
  output logic              busy,
  output logic              ack,
  output logic [WORD_W-1:0] rdata,
  output logic              err
);

  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]        WAIT_L  = 4'(WAIT_CYC);

  dm_state_e         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic              accept_s;
  logic              eff_we_s;
  logic [ADDR_W-1:0] eff_addr_s;
  logic              in_range_s;
  logic              wr_en_s;
  logic [WORD_W-1:0] rd_word_s;

  assign accept_s = (state_q == ST_IDLE) && req;

  // With zero wait states the response is formed on the acceptance edge,
  // before the request fields are latched, so look at the live inputs then.
  assign eff_we_s   = (state_q == ST_IDLE) ? we   : we_q;
  assign eff_addr_s = (state_q == ST_IDLE) ? addr : addr_q;
  assign in_range_s = {1'b0, eff_addr_s} < DEPTH_L;

  // The store commits on the edge that ends RESP; a reset on that edge
  // discards it.
  assign wr_en_s = (state_q == ST_RESP) && we_q && in_range_s && !rst;

  dm_wait_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en_s),
    .waddr_i (addr_q[IDX_W-1:0]),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .raddr_i (eff_addr_s[IDX_W-1:0]),
    .rdata_o (rd_word_s)
  );

  // Next-state, wait counter and next output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cnt_d   = WAIT_L;
          state_d = (WAIT_L == 4'd0) ? ST_RESP : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    ack_d = (state_d == ST_RESP);
    err_d = ack_d && !in_range_s;
    if (ack_d && !eff_we_s && in_range_s) begin
      rdata_d = rd_word_s;
    end else begin
      rdata_d = {WORD_W{1'b0}};
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= {WORD_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Request fields are captured only on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {WORD_W{1'b0}};
      be_q    <= 4'd0;
    end else if (accept_s) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
      be_q    <= be;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_wait_resp.sv
module tb_dm_wait_resp;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_v   [2];
  logic        req_v   [2];
  logic        we_v    [2];
  logic [10:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [3:0]  be_v    [2];
  logic        busy_v  [2];
  logic        ack_v   [2];
  logic [31:0] rdata_v [2];
  logic        err_v   [2];

  exp_t q0[$];
  exp_t q1[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_wait_resp #(.DEPTH(1024), .ADDR_W(11), .WAIT_CYC(2)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .be(be_v[0]), .busy(busy_v[0]), .ack(ack_v[0]),
    .rdata(rdata_v[0]), .err(err_v[0]));

  dm_wait_resp #(.DEPTH(1024), .ADDR_W(11), .WAIT_CYC(0)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .be(be_v[1]), .busy(busy_v[1]), .ack(ack_v[1]),
    .rdata(rdata_v[1]), .err(err_v[1]));

  function automatic int wc(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h, want %h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int c, input logic [31:0] r, input logic e);
    exp_t x;
    x.cyc = c; x.rdata = r; x.err = e;
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  // Monitor: pops an expectation for every ack; outside ack, rdata/err must be 0.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ack_v[d]) begin
        exp_t x;
        n_cmp++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          n_bad++;
          $display("FAIL unexpected_ack dut%0d: got ack at cycle %0d, want none", d, cyc);
        end else begin
          x = (d == 0) ? q0.pop_front() : q1.pop_front();
          if (x.cyc != cyc || rdata_v[d] !== x.rdata || err_v[d] !== x.err) begin
            n_bad++;
            $display("FAIL resp dut%0d: got cyc=%0d rdata=%h err=%b, want cyc=%0d rdata=%h err=%b",
                     d, cyc, rdata_v[d], err_v[d], x.cyc, x.rdata, x.err);
          end
        end
      end else if (rst_v[d] === 1'b0) begin
        n_cmp++;
        if (rdata_v[d] !== 32'd0 || err_v[d] !== 1'b0) begin
          n_bad++;
          $display("FAIL idle_out dut%0d: got rdata=%h err=%b, want 0/0", d, rdata_v[d], err_v[d]);
        end
      end
    end
  end

  // Called at a negedge with busy=0; returns at the first negedge with busy=0 again.
  task automatic op(input int d, input logic we, input logic [10:0] a, input logic [31:0] wd,
                    input logic [3:0] be, input logic [31:0] er, input logic ee, input bit poke);
    int w;
    w = wc(d);
    we_v[d] = we; addr_v[d] = a; wdata_v[d] = wd; be_v[d] = be; req_v[d] = 1'b1;
    push(d, cyc + 1 + w, er, ee);
    @(negedge clk);
    req_v[d] = 1'b0; addr_v[d] = ~a; wdata_v[d] = ~wd; be_v[d] = ~be; we_v[d] = ~we;
    for (int i = 0; i <= w; i++) begin
      chk("busy", d, {31'd0, busy_v[d]}, 32'd1);
      if (poke && i == 0) begin
        req_v[d] = 1'b1; addr_v[d] = 11'd0; we_v[d] = 1'b0;
      end
      @(negedge clk);
      req_v[d] = 1'b0;
    end
    chk("busy_end", d, {31'd0, busy_v[d]}, 32'd0);
  endtask

  task automatic rst_dut(input int d);
    rst_v[d] = 1'b1;
    repeat (2) @(negedge clk);
    rst_v[d] = 1'b0;
    chk("rst_busy", d, {31'd0, busy_v[d]}, 32'd0);
    chk("rst_ack", d, {31'd0, ack_v[d]}, 32'd0);
    chk("rst_err", d, {31'd0, err_v[d]}, 32'd0);
    chk("rst_rdata", d, rdata_v[d], 32'd0);
  endtask

  // Store aborted by reset asserted in the RESP cycle (ack already showing).
  task automatic rst_in_resp(input int d, input logic [10:0] a, input logic [31:0] wd);
    int w;
    w = wc(d);
    we_v[d] = 1'b1; addr_v[d] = a; wdata_v[d] = wd; be_v[d] = 4'hF; req_v[d] = 1'b1;
    push(d, cyc + 1 + w, 32'd0, 1'b0);
    @(negedge clk);
    req_v[d] = 1'b0;
    repeat (w) @(negedge clk);
    rst_v[d] = 1'b1;
    @(negedge clk);
    rst_v[d] = 1'b0;
    chk("rstresp_busy", d, {31'd0, busy_v[d]}, 32'd0);
  endtask

  // Store aborted by reset in WAIT: no ack at all.
  task automatic rst_in_wait(input int d, input logic [10:0] a, input logic [31:0] wd);
    we_v[d] = 1'b1; addr_v[d] = a; wdata_v[d] = wd; be_v[d] = 4'hF; req_v[d] = 1'b1;
    @(negedge clk);
    req_v[d] = 1'b0;
    rst_v[d] = 1'b1;
    @(negedge clk);
    rst_v[d] = 1'b0;
    chk("rstwait_busy", d, {31'd0, busy_v[d]}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_seq(input int d);
    rst_dut(d);
    op(d, 1'b1, 11'd5,    32'h0000_0000, 4'hF, 32'd0, 1'b0, 1'b0);
    op(d, 1'b0, 11'd5,    32'd0,         4'h0, 32'h0000_0000, 1'b0, 1'b0);
    op(d, 1'b1, 11'd5,    32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0, 1'b0);
    op(d, 1'b0, 11'd5,    32'd0,         4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    op(d, 1'b1, 11'd5,    32'h1122_3344, 4'h5, 32'd0, 1'b0, 1'b0);
    op(d, 1'b0, 11'd5,    32'd0,         4'h0, 32'hDE22_BE44, 1'b0, 1'b0);
    op(d, 1'b1, 11'd0,    32'h0000_0000, 4'hF, 32'd0, 1'b0, 1'b0);
    op(d, 1'b1, 11'd1024, 32'hA5A5_A5A5, 4'hF, 32'd0, 1'b1, 1'b0);
    op(d, 1'b0, 11'd0,    32'd0,         4'h0, 32'h0000_0000, 1'b0, 1'b0);
    op(d, 1'b0, 11'd1024, 32'd0,         4'h0, 32'd0, 1'b1, 1'b0);
    op(d, 1'b0, 11'd2047, 32'd0,         4'h0, 32'd0, 1'b1, 1'b0);
    op(d, 1'b1, 11'd5,    32'hFFFF_FFFF, 4'h0, 32'd0, 1'b0, 1'b0);
    op(d, 1'b0, 11'd5,    32'd0,         4'h0, 32'hDE22_BE44, 1'b0, 1'b0);
    op(d, 1'b0, 11'd5,    32'd0,         4'h0, 32'hDE22_BE44, 1'b0, 1'b1);
    op(d, 1'b1, 11'd7,    32'h1234_5678, 4'hF, 32'd0, 1'b0, 1'b0);
    rst_in_resp(d, 11'd7, 32'hCAFE_F00D);
    op(d, 1'b0, 11'd7,    32'd0,         4'h0, 32'h1234_5678, 1'b0, 1'b0);
    if (wc(d) > 0) begin
      rst_in_wait(d, 11'd7, 32'hCAFE_F00D);
      op(d, 1'b0, 11'd7,  32'd0,         4'h0, 32'h1234_5678, 1'b0, 1'b0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1; req_v[d] = 1'b0; we_v[d] = 1'b0; addr_v[d] = 11'd0;
      wdata_v[d] = 32'd0; be_v[d] = 4'd0;
    end
    repeat (3) @(negedge clk);
    rst_v[1] = 1'b0;
    run_seq(0);
    run_seq(1);
    repeat (6) @(negedge clk);
    chk("pending_dut0", 0, q0.size(), 32'd0);
    chk("pending_dut1", 1, q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
